// File: rtl/pfb_bin_select.sv
// Bin-range selector for channelised frames: forwards a contiguous bin window of each
// frame and re-frames it with tlast on the last selected bin.
module pfb_bin_select #(
    parameter int unsigned BASE          = 140,
    parameter int unsigned MAX_BINS_LOG2 = 10,
    parameter int unsigned WIDTH         = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             set_stb,
    input  logic [7:0]       set_addr,
    input  logic [31:0]      set_data,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tlast,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic             frame_err
);

    localparam int unsigned CW = MAX_BINS_LOG2;
    localparam int unsigned NW = MAX_BINS_LOG2 + 1;

    localparam logic [7:0]    ADDR_LOG2  = 8'(BASE);
    localparam logic [7:0]    ADDR_START = 8'(BASE + 1);
    localparam logic [7:0]    ADDR_NUM   = 8'(BASE + 2);
    localparam logic [3:0]    LOG2_MAX   = 4'(MAX_BINS_LOG2);
    localparam logic [NW-1:0] NUM_ALL    = {1'b1, {CW{1'b0}}};
    localparam logic [NW-1:0] ONE_N      = {{(NW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] ONE_C      = {{(CW-1){1'b0}}, 1'b1};

    // Shadow (bus-written) and active (frame-aligned) configuration
    logic [3:0]    r_sh_log2, r_log2;
    logic [CW-1:0] r_sh_start, r_start;
    logic [NW-1:0] r_sh_num, r_num;

    logic [CW-1:0]    r_bin_cnt;
    logic             r_out_open;
    logic             r_valid;
    logic             r_last;
    logic [WIDTH-1:0] r_data;
    logic             r_frame_err;

    logic [3:0]    w_log2_clamped;
    logic          w_acc;
    logic          w_cfg_load;
    logic [NW-1:0] w_nbins;
    logic [NW-1:0] w_nbins_m1;
    logic [NW:0]   w_sum;
    logic [NW:0]   w_sum_m1;
    logic [NW-1:0] w_last_sel;
    logic          w_empty;
    logic          w_sel;
    logic          w_sel_last;
    logic          w_is_last_bin;
    logic          w_early;
    logic          w_emit;
    logic          w_emit_last;
    logic          unused_set_data;

    assign unused_set_data = ^set_data[31:NW];

    always_comb begin
        w_log2_clamped = set_data[3:0];
        if (set_data[3:0] == 4'd0) begin
            w_log2_clamped = 4'd1;
        end else if (set_data[3:0] > LOG2_MAX) begin
            w_log2_clamped = LOG2_MAX;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sh_log2  <= LOG2_MAX;
            r_sh_start <= '0;
            r_sh_num   <= NUM_ALL;
        end else if (set_stb) begin
            if (set_addr == ADDR_LOG2) begin
                r_sh_log2 <= w_log2_clamped;
            end
            if (set_addr == ADDR_START) begin
                r_sh_start <= set_data[CW-1:0];
            end
            if (set_addr == ADDR_NUM) begin
                r_sh_num <= set_data[NW-1:0];
            end
        end
    end

    assign i_tready   = ~r_valid | o_tready;
    assign w_acc      = i_tvalid & i_tready;
    // Only an idle frame boundary may swap config, so a frame never sees two ranges
    assign w_cfg_load = (r_bin_cnt == '0) & ~w_acc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_log2  <= LOG2_MAX;
            r_start <= '0;
            r_num   <= NUM_ALL;
        end else if (w_cfg_load) begin
            r_log2  <= r_sh_log2;
            r_start <= r_sh_start;
            r_num   <= r_sh_num;
        end
    end

    // Range end evaluated one bit wider than nbins so start+num-1 cannot wrap
    assign w_nbins    = ONE_N << r_log2;
    assign w_nbins_m1 = w_nbins - ONE_N;
    assign w_sum      = {2'b00, r_start} + {1'b0, r_num};
    assign w_sum_m1   = w_sum - {1'b0, ONE_N};
    assign w_last_sel = (w_sum_m1 > {1'b0, w_nbins_m1}) ? w_nbins_m1 : w_sum_m1[NW-1:0];
    assign w_empty    = (r_num == '0) | ({1'b0, r_start} >= w_nbins);

    assign w_sel         = ~w_empty & (r_bin_cnt >= r_start) & ({1'b0, r_bin_cnt} <= w_last_sel);
    assign w_sel_last    = ({1'b0, r_bin_cnt} == w_last_sel);
    assign w_is_last_bin = ({1'b0, r_bin_cnt} == w_nbins_m1);
    assign w_early       = i_tlast & ~w_is_last_bin;
    // An early tlast still closes an output frame that is already open
    assign w_emit        = w_sel | (w_early & r_out_open);
    assign w_emit_last   = w_early | w_sel_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bin_cnt  <= '0;
            r_out_open <= 1'b0;
        end else if (w_acc) begin
            if (w_is_last_bin || w_early) begin
                r_bin_cnt <= '0;
            end else begin
                r_bin_cnt <= r_bin_cnt + ONE_C;
            end
            if (w_emit) begin
                r_out_open <= ~w_emit_last;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
        end else if (w_acc && w_emit) begin
            r_valid <= 1'b1;
            r_last  <= w_emit_last;
            r_data  <= i_tdata;
        end else if (o_tready) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_acc & w_early;
        end
    end

    assign o_tvalid  = r_valid;
    assign o_tlast   = r_last;
    assign o_tdata   = r_data;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_pfb_bin_select.sv
// Bench for pfb_bin_select: frame-level reference model of the selected bin window,
// compared beat by beat against the captured output stream.
module tb_pfb_bin_select;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        set_stb = 1'b0;
    logic [7:0]  set_addr = 8'd0;
    logic [31:0] set_data = 32'd0;
    logic [31:0] i_tdata = 32'd0;
    logic        i_tlast = 1'b0;
    logic        i_tvalid = 1'b0;
    logic        i_tready;
    logic [31:0] o_tdata;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready = 1'b1;
    logic        frame_err;

    pfb_bin_select #(
        .BASE          (140),
        .MAX_BINS_LOG2 (10),
        .WIDTH         (32)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .set_stb   (set_stb),
        .set_addr  (set_addr),
        .set_data  (set_data),
        .i_tdata   (i_tdata),
        .i_tlast   (i_tlast),
        .i_tvalid  (i_tvalid),
        .i_tready  (i_tready),
        .o_tdata   (o_tdata),
        .o_tlast   (o_tlast),
        .o_tvalid  (o_tvalid),
        .o_tready  (o_tready),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int rdy_mode = 0;   // 0 always ready, 1 random, 2 stalled

    logic [32:0] got_q [$];
    logic [32:0] exp_q [$];
    int err_cnt = 0;
    int m_err = 0;
    int stall_cnt = 0;
    int stab_err = 0;
    bit p_stall = 0;
    logic [31:0] p_data;
    logic        p_last;

    int m_sh_log2, m_sh_start, m_sh_num;
    int m_log2, m_start, m_num;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       o_tready = 1'b1;
            1:       o_tready = 1'($urandom_range(0, 1));
            default: o_tready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (o_tvalid && o_tready) got_q.push_back({o_tlast, o_tdata});
            if (frame_err) err_cnt++;
            if (i_tvalid && !i_tready) stall_cnt++;
            if (p_stall && (!o_tvalid || o_tdata !== p_data || o_tlast !== p_last)) stab_err++;
            p_stall = o_tvalid && !o_tready;
            p_data  = o_tdata;
            p_last  = o_tlast;
        end else begin
            p_stall = 0;
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    task automatic model_defaults();
        m_sh_log2 = 10; m_sh_start = 0; m_sh_num = 1024;
        m_log2 = 10; m_start = 0; m_num = 1024;
    endtask

    task automatic write_reg(input logic [7:0] a, input logic [31:0] d);
        int l;
        set_addr = a; set_data = d; set_stb = 1'b1;
        @(posedge clk); #1;
        set_stb = 1'b0;
        if (a == 8'd140) begin
            l = int'(d[3:0]);
            if (l == 0) l = 1;
            if (l > 10) l = 10;
            m_sh_log2 = l;
        end else if (a == 8'd141) begin
            m_sh_start = int'(d[9:0]);
        end else if (a == 8'd142) begin
            m_sh_num = int'(d[10:0]);
        end
    endtask

    task automatic cfg(input int l, input int s, input int n);
        write_reg(8'd140, 32'(l));
        write_reg(8'd141, 32'(s));
        write_reg(8'd142, 32'(n));
    endtask

    task automatic send_beat(input logic [31:0] d, input logic l);
        int n = 0;
        i_tdata = d; i_tlast = l; i_tvalid = 1'b1;
        @(negedge clk);
        while (!i_tready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            n_tests++; n_fail++;
            $display("FAIL beat_accept_timeout: i_tready=%b for %0d cycles, required 1", i_tready, n);
        end
        @(posedge clk); #1;
        i_tvalid = 1'b0; i_tlast = 1'b0;
    endtask

    // Frame of n beats with tlast on the last; the model applies the shadow config at frame start
    task automatic send_frame(input int n, input bit ramp, input bit gaps, input int wr_at,
                              input logic [7:0] wa, input logic [31:0] wd);
        logic [31:0] d [$];
        int nb, hi, e;
        bit empty;
        repeat (2) begin @(posedge clk); #1; end
        m_log2 = m_sh_log2; m_start = m_sh_start; m_num = m_sh_num;
        nb = 1 << m_log2;
        hi = m_start + m_num - 1;
        if (hi > nb - 1) hi = nb - 1;
        empty = (m_num == 0) || (m_start >= nb);
        e = n - 1;
        if (e != nb - 1) m_err++;
        for (int i = 0; i < n; i++) begin
            d.push_back(ramp ? 32'(i) : $urandom);
            if (!empty && i >= m_start && i <= hi) exp_q.push_back({(i == hi) || (i == e), d[i]});
        end
        for (int i = 0; i < n; i++) begin
            if (i == wr_at) write_reg(wa, wd);
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send_beat(d[i], i == e);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (got_q.size() < exp_q.size() && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) begin @(posedge clk); #1; end
        if (n >= 5000) begin
            n_tests++; n_fail++;
            $display("FAIL drain_timeout: got %0d beats, required %0d", got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        n_tests += 4;
        if (o_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_tvalid: got %b required 0", o_tvalid); end
        if (o_tlast !== 1'b0) begin n_fail++; $display("FAIL rst_tlast: got %b required 0", o_tlast); end
        if (o_tdata !== 32'd0) begin n_fail++; $display("FAIL rst_tdata: got %h required 0", o_tdata); end
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL rst_frame_err: got %b required 0", frame_err); end
        reset_n = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (i_tready !== 1'b1) begin n_fail++; $display("FAIL rst_tready: got %b required 1", i_tready); end
        model_defaults();
    endtask

    task automatic test_pass_all();
        int g0 = got_q.size();
        int s0 = stall_cnt;
        rdy_mode = 0;
        send_frame(1024, 1, 0, -1, 8'd0, 32'd0);
        send_frame(1024, 1, 0, -1, 8'd0, 32'd0);
        wait_drain();
        n_tests += 3;
        if (got_q.size() - g0 != 2048) begin n_fail++; $display("FAIL pass_all_count: got %0d required 2048", got_q.size() - g0); end
        if (stall_cnt != s0) begin n_fail++; $display("FAIL pass_all_throughput: got %0d stalls required 0", stall_cnt - s0); end
        if (err_cnt != m_err) begin n_fail++; $display("FAIL pass_all_err: got %0d required %0d", err_cnt, m_err); end
        for (int i = g0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL pass_all_beat[%0d]: got %h required %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_range();
        int g0 = got_q.size();
        cfg(4, 3, 4);
        send_frame(16, 1, 0, -1, 8'd0, 32'd0);
        send_frame(16, 1, 0, -1, 8'd0, 32'd0);
        cfg(4, 12, 10);
        send_frame(16, 1, 0, -1, 8'd0, 32'd0);
        wait_drain();
        n_tests += 2;
        if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL range_count: got %0d required %0d", got_q.size(), exp_q.size()); end
        if (err_cnt != m_err) begin n_fail++; $display("FAIL range_err: got %0d required %0d", err_cnt, m_err); end
        for (int i = g0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL range_beat[%0d]: got %h required %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_early_tlast();
        int g0 = got_q.size();
        int e0 = err_cnt;
        cfg(4, 2, 8);
        send_frame(6, 1, 0, -1, 8'd0, 32'd0);
        send_frame(16, 1, 0, -1, 8'd0, 32'd0);
        send_frame(3, 1, 0, -1, 8'd0, 32'd0);
        send_frame(12, 1, 0, -1, 8'd0, 32'd0);
        wait_drain();
        n_tests += 3;
        if (err_cnt - e0 != 3) begin n_fail++; $display("FAIL early_err_pulses: got %0d required 3", err_cnt - e0); end
        if (err_cnt != m_err) begin n_fail++; $display("FAIL early_err_total: got %0d required %0d", err_cnt, m_err); end
        if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL early_count: got %0d required %0d", got_q.size(), exp_q.size()); end
        for (int i = g0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL early_beat[%0d]: got %h required %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        int g0 = got_q.size();
        int b0 = stab_err;
        cfg(4, 1, 2);
        rdy_mode = 1;
        for (int f = 0; f < 8; f++) send_frame(16, 0, 1, -1, 8'd0, 32'd0);
        cfg(3, 0, 8);
        for (int f = 0; f < 4; f++) send_frame(8, 0, 1, -1, 8'd0, 32'd0);
        wait_drain();
        rdy_mode = 0;
        n_tests += 2;
        if (stab_err != b0) begin n_fail++; $display("FAIL bp_hold_stable: got %0d changes required 0", stab_err - b0); end
        if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL bp_count: got %0d required %0d", got_q.size(), exp_q.size()); end
        for (int i = g0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_beat[%0d]: got %h required %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_midframe_cfg();
        int g0 = got_q.size();
        cfg(4, 2, 4);
        send_frame(16, 1, 0, 7, 8'd141, 32'd5);
        send_frame(16, 1, 0, 0, 8'd142, 32'd2);
        send_frame(16, 1, 0, -1, 8'd0, 32'd0);
        wait_drain();
        n_tests++;
        if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL midcfg_count: got %0d required %0d", got_q.size(), exp_q.size()); end
        for (int i = g0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL midcfg_beat[%0d]: got %h required %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_clamp();
        int g0 = got_q.size();
        cfg(15, 1020, 8);
        send_frame(1024, 1, 0, -1, 8'd0, 32'd0);
        cfg(0, 0, 2);
        send_frame(2, 0, 0, -1, 8'd0, 32'd0);
        send_frame(2, 0, 0, -1, 8'd0, 32'd0);
        wait_drain();
        n_tests += 2;
        if (err_cnt != m_err) begin n_fail++; $display("FAIL clamp_err: got %0d required %0d", err_cnt, m_err); end
        if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL clamp_count: got %0d required %0d", got_q.size(), exp_q.size()); end
        for (int i = g0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL clamp_beat[%0d]: got %h required %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_mid_reset();
        int g0;
        cfg(4, 2, 1);
        repeat (2) begin @(posedge clk); #1; end
        rdy_mode = 2;
        @(posedge clk); #1;
        send_beat(32'hA0, 1'b0);
        send_beat(32'hA1, 1'b0);
        send_beat(32'hA2, 1'b0);
        n_tests += 2;
        if (o_tvalid !== 1'b1 || o_tlast !== 1'b1) begin
            n_fail++; $display("FAIL held_beat_flags: got valid=%b last=%b required 1 1", o_tvalid, o_tlast);
        end
        if (o_tdata !== 32'hA2) begin n_fail++; $display("FAIL held_beat_data: got %h required a2", o_tdata); end
        reset_n = 1'b0;
        #2;
        n_tests += 2;
        if (o_tvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_tvalid: got %b required 0", o_tvalid); end
        if (o_tdata !== 32'd0) begin n_fail++; $display("FAIL midrst_tdata: got %h required 0", o_tdata); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        rdy_mode = 0;
        model_defaults();
        g0 = got_q.size();
        cfg(4, 0, 16);
        send_frame(16, 0, 0, -1, 8'd0, 32'd0);
        wait_drain();
        n_tests += 2;
        if (err_cnt != m_err) begin n_fail++; $display("FAIL midrst_err: got %0d required %0d", err_cnt, m_err); end
        if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL midrst_count: got %0d required %0d", got_q.size(), exp_q.size()); end
        for (int i = g0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL midrst_beat[%0d]: got %h required %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        int g0 = got_q.size();
        int l, lc, nb, n;
        rdy_mode = 1;
        for (int k = 0; k < 10; k++) begin
            l  = int'($urandom_range(0, 6));
            lc = (l == 0) ? 1 : l;
            nb = 1 << lc;
            cfg(l, int'($urandom_range(0, nb + 1)), int'($urandom_range(0, nb + 2)));
            for (int f = 0; f < 3; f++) begin
                n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, nb)) : nb;
                send_frame(n, 0, 1, -1, 8'd0, 32'd0);
            end
        end
        wait_drain();
        rdy_mode = 0;
        n_tests += 2;
        if (err_cnt != m_err) begin n_fail++; $display("FAIL rand_err: got %0d required %0d", err_cnt, m_err); end
        if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d required %0d", got_q.size(), exp_q.size()); end
        for (int i = g0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_beat[%0d]: got %h required %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_pass_all();
        test_range();
        test_early_tlast();
        test_backpressure();
        test_midframe_cfg();
        test_clamp();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
